// File: rtl/inst_fetch_pkg.sv
// Shared constants, the IF-ID payload type and PC helpers for the instruction-fetch slice.
package inst_fetch_pkg;

  localparam int          XLEN             = 32;
  localparam int          BUF_DEPTH        = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  // Sequential fetch step; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ROM port, redirect input and IF-ID handshake bundled for the fetch unit.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic [XLEN-1:0] inst_addr;
  logic [XLEN-1:0] inst_i;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;

  modport master (
    output inst_addr, if_valid, if_pc, if_inst,
    input  inst_i, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  inst_addr, if_valid, if_pc, if_inst,
    output inst_i, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/inst_fetch_buf.sv
// Two-entry {pc, inst} response FIFO with flush, plus its overflow checker.
module fetch_buf
  import inst_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  if_entry_t  din,
  output if_entry_t  head,
  output logic [1:0] count
);

  if_entry_t  mem_r [BUF_DEPTH];
  logic       rd_ptr_r;
  logic       wr_ptr_r;
  logic [1:0] count_r;
  logic       do_push_s;
  logic       do_pop_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_push_s = push && (count_r != 2'd2);
      do_pop_s  = pop  && (count_r != 2'd0);
    end
  end

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_r[i] <= '0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// Observes the FIFO for a push arriving while it is already full.
module fetch_buf_chk (
  input logic       clk,
  input logic       rstn,
  input logic       push,
  input logic [1:0] count
);

  no_overflow_a: assert property (@(posedge clk) disable iff (!rstn) push |-> (count != 2'd2));

endmodule

// File: rtl/inst_fetch.sv
// Fetch initiator: owns the PC, tracks the single in-flight ROM read and bypasses or buffers responses.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input logic          clk,
  input logic          rstn,
  inst_fetch_if.master bus
);

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic            req_vld_r;

  logic [1:0]      count_s;
  if_entry_t       head_s;
  if_entry_t       resp_s;
  logic            buf_empty_s;
  logic            issue_s;
  logic            out_valid_s;
  logic            xfer_s;
  logic            push_s;
  logic            pop_s;

  // Credit-based issue and the bypass/buffer steering; a redirect squashes everything this cycle.
  always_comb begin
    buf_empty_s  = (count_s == 2'd0);
    resp_s.pc    = req_pc_r;
    resp_s.inst  = bus.inst_i;
    issue_s      = 1'b0;
    out_valid_s  = 1'b0;
    xfer_s       = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    if (bus.redirect_valid) begin
      issue_s     = 1'b0;
      out_valid_s = 1'b0;
    end else begin
      issue_s     = (({1'b0, count_s} + {2'b00, req_vld_r}) < 3'd2);
      out_valid_s = !buf_empty_s || req_vld_r;
      xfer_s      = out_valid_s && bus.if_ready;
      // A response is parked unless it went straight out over the bypass.
      push_s      = req_vld_r && !(buf_empty_s && xfer_s);
      pop_s       = xfer_s && !buf_empty_s;
    end
  end

  // Decode-side payload; buffered head has priority to keep program order.
  always_comb begin
    bus.if_valid = out_valid_s;
    bus.if_pc    = 32'h0000_0000;
    bus.if_inst  = 32'h0000_0000;
    if (!out_valid_s) begin
      bus.if_pc   = 32'h0000_0000;
      bus.if_inst = 32'h0000_0000;
    end else if (!buf_empty_s) begin
      bus.if_pc   = head_s.pc;
      bus.if_inst = head_s.inst;
    end else begin
      bus.if_pc   = resp_s.pc;
      bus.if_inst = resp_s.inst;
    end
  end

  assign bus.inst_addr = fetch_pc_r;

  // Fetch PC and in-flight request tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_r <= align_pc(RESET_PC);
      req_vld_r  <= 1'b0;
      req_pc_r   <= 32'h0000_0000;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc_r <= align_pc(bus.redirect_pc);
      end else if (issue_s) begin
        fetch_pc_r <= next_pc(fetch_pc_r);
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      req_vld_r <= issue_s;
      if (issue_s) begin
        req_pc_r <= fetch_pc_r;
      end else begin
        req_pc_r <= req_pc_r;
      end
    end
  end

  fetch_buf u_buf (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.redirect_valid),
    .din   (resp_s),
    .head  (head_s),
    .count (count_s)
  );

  fetch_buf_chk u_buf_chk (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_s),
    .count (count_s)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed and scoreboarded checks of inst_fetch against a ROM whose word i holds 0x1000_0000+i.
module tb_inst_fetch;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  inst_fetch_if bus_if();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return 32'h1000_0000 + {2'b00, pc[31:2]};
  endfunction

  // Synchronous-read ROM model.
  always @(posedge clk) bus_if.inst_i <= exp_inst(bus_if.inst_addr);

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    adv();
    adv();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus_if.if_ready       = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0000_0000;
    #1;
    checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus_if.if_valid); end
    checks++; if (bus_if.if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus_if.if_pc); end
    checks++; if (bus_if.if_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", bus_if.if_inst); end
    checks++; if (bus_if.inst_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus_if.inst_addr); end
    adv();
    adv();
    rstn = 1'b1;
    #3;
    checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b exp 0", bus_if.if_valid); end
  endtask

  task automatic test_stream();
    bus_if.if_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      adv();
      #3;
      checks++; if (bus_if.if_valid !== 1'b1 || bus_if.if_pc !== 32'(4*i) || bus_if.if_inst !== 32'h1000_0000 + 32'(i)) begin
        errors++; $display("FAIL stream_%0d got v=%b pc=%h inst=%h exp pc=%h", i, bus_if.if_valid, bus_if.if_pc, bus_if.if_inst, 32'(4*i));
      end
    end
  endtask

  task automatic test_stall();
    bus_if.if_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      adv();
      #3;
      checks++; if (bus_if.if_valid !== 1'b1 || bus_if.if_pc !== 32'h0) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b pc=%h exp pc=0", i, bus_if.if_valid, bus_if.if_pc);
      end
    end
    // pc 0 and pc 4 fill both entries, so fetch halts at the next address.
    checks++; if (bus_if.inst_addr !== 32'h0000_0008) begin errors++; $display("FAIL stall_addr got %h exp 8", bus_if.inst_addr); end
    for (int i = 0; i < 4; i++) begin
      adv();
      bus_if.if_ready = 1'b1;
      #3;
      checks++; if (bus_if.if_valid !== 1'b1 || bus_if.if_pc !== 32'(4*i) || bus_if.if_inst !== 32'h1000_0000 + 32'(i)) begin
        errors++; $display("FAIL release_%0d got v=%b pc=%h inst=%h exp pc=%h", i, bus_if.if_valid, bus_if.if_pc, bus_if.if_inst, 32'(4*i));
      end
    end
  endtask

  task automatic test_redirect_full();
    bus_if.if_ready = 1'b0;
    do_reset();
    adv();
    adv();
    adv();
    adv();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h0000_0103;
    #3;
    checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL redir_t_valid got %b exp 0", bus_if.if_valid); end
    adv();
    bus_if.redirect_valid = 1'b0;
    bus_if.if_ready       = 1'b1;
    #3;
    checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL redir_t1_valid got %b exp 0", bus_if.if_valid); end
    checks++; if (bus_if.inst_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_t1_addr got %h exp 100", bus_if.inst_addr); end
    adv();
    #3;
    checks++; if (bus_if.if_valid !== 1'b1 || bus_if.if_pc !== 32'h100 || bus_if.if_inst !== 32'h1000_0040) begin
      errors++; $display("FAIL redir_t2 got v=%b pc=%h inst=%h exp pc=100 inst=10000040", bus_if.if_valid, bus_if.if_pc, bus_if.if_inst);
    end
    adv();
    #3;
    checks++; if (bus_if.if_pc !== 32'h104) begin errors++; $display("FAIL redir_t3 got %h exp 104", bus_if.if_pc); end
    adv();
    #3;
    checks++; if (bus_if.if_pc !== 32'h108) begin errors++; $display("FAIL redir_t4 got %h exp 108", bus_if.if_pc); end
  endtask

  task automatic test_redirect_handshake();
    adv();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h0000_0200;
    #3;
    checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL hs_redir_valid got %b exp 0", bus_if.if_valid); end
    adv();
    bus_if.redirect_valid = 1'b0;
    #3;
    checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL hs_bubble got %b exp 0", bus_if.if_valid); end
    adv();
    #3;
    checks++; if (bus_if.if_valid !== 1'b1 || bus_if.if_pc !== 32'h200) begin
      errors++; $display("FAIL hs_target got v=%b pc=%h exp pc=200", bus_if.if_valid, bus_if.if_pc);
    end
    adv();
    #3;
    checks++; if (bus_if.if_pc !== 32'h204) begin errors++; $display("FAIL hs_next got %h exp 204", bus_if.if_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    adv();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'hFFFF_FFF8;
    #3;
    adv();
    bus_if.redirect_valid = 1'b0;
    e = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      adv();
      #3;
      checks++; if (bus_if.if_valid !== 1'b1 || bus_if.if_pc !== e || bus_if.if_inst !== exp_inst(e)) begin
        errors++; $display("FAIL wrap_%0d got v=%b pc=%h inst=%h exp pc=%h", i, bus_if.if_valid, bus_if.if_pc, bus_if.if_inst, e);
      end
      e = e + 32'd4;
    end
  endtask

  task automatic test_soak();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    int          n_xfer;
    n_xfer = 0;
    bus_if.if_ready = 1'b1;
    do_reset();
    exp_pc = 32'h0;
    for (int c = 0; c < 400; c++) begin
      adv();
      if (c == 200) rstn = 1'b0;
      if (c == 203) rstn = 1'b1;
      tgt = $urandom;
      bus_if.if_ready       = ($urandom_range(0, 3) != 0);
      bus_if.redirect_valid = rstn && ($urandom_range(0, 19) == 0);
      bus_if.redirect_pc    = tgt;
      #3;
      if (!rstn) begin
        exp_pc = 32'h0;
        checks++; if (bus_if.if_valid !== 1'b0 || bus_if.if_pc !== 32'h0 || bus_if.if_inst !== 32'h0 || bus_if.inst_addr !== 32'h0) begin
          errors++; $display("FAIL soak_reset c=%0d got v=%b pc=%h inst=%h addr=%h exp all 0", c, bus_if.if_valid, bus_if.if_pc, bus_if.if_inst, bus_if.inst_addr);
        end
      end else if (bus_if.redirect_valid) begin
        exp_pc = {tgt[31:2], 2'b00};
        checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL soak_redir c=%0d got v=%b exp 0", c, bus_if.if_valid); end
      end else if (bus_if.if_valid && bus_if.if_ready) begin
        checks++; if (bus_if.if_pc !== exp_pc || bus_if.if_inst !== exp_inst(exp_pc)) begin
          errors++; $display("FAIL soak_order c=%0d got pc=%h inst=%h exp pc=%h inst=%h", c, bus_if.if_pc, bus_if.if_inst, exp_pc, exp_inst(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end else if (!bus_if.if_valid) begin
        checks++; if (bus_if.if_pc !== 32'h0 || bus_if.if_inst !== 32'h0) begin
          errors++; $display("FAIL soak_idle_zero c=%0d got pc=%h inst=%h exp 0", c, bus_if.if_pc, bus_if.if_inst);
        end
      end
    end
    bus_if.redirect_valid = 1'b0;
    checks++; if (n_xfer < 150) begin errors++; $display("FAIL soak_throughput got %0d exp >=150", n_xfer); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_handshake();
    test_wrap();
    test_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout exp finish before 100000");
    $fatal(1);
  end

endmodule
